// File: rtl/shift_seq_pkg.sv
// Shared types, mode encodings and the command-length clamp for the shift sequencer.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic MODE_TX = 1'b0;
    localparam logic MODE_RX = 1'b1;

    // A length of zero or anything beyond the register width means "the whole register".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        if (len == 0 || len > width) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/shift_pace_counter.sv
// DIV-cycle down-counter that paces shift steps; tick_o marks the last gap cycle.
module shift_pace_counter #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(DIV - 1);

    logic [PW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (en_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // With DIV==1 the sequencer never enters GAP, so a constant tick is harmless.
    assign tick_o = (DIV == 1) ? 1'b1 : (en_i && count_q == PW'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for an external shift_register: TX serializes a byte, RX captures bits.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int   WIDTH   = 8,
    parameter int   DIV     = 1,
    parameter logic TX_FILL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_mode,
    input  logic [WIDTH-1:0]           cmd_data,
    input  logic [$clog2(WIDTH):0]     cmd_len,
    input  logic                       ser_in,
    output logic                       ser_out,
    output logic                       ser_strobe,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy,
    output logic                       sr_load_en,
    output logic                       sr_shift_en,
    output logic [WIDTH-1:0]           sr_parallel_in,
    output logic                       sr_serial_in,
    input  logic [WIDTH-1:0]           sr_q
);

    localparam int LEN_W = $clog2(WIDTH) + 1;
    localparam bit PACED = (DIV > 1);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   cnt_inc;
    logic [WIDTH-1:0]   rsp_q, rsp_d;
    logic               pace_tick;

    shift_pace_counter #(
        .DIV(DIV)
    ) u_pace (
        .clk    (clk),
        .rst_n  (rst),
        .load_i (state_q == ST_SHIFT),
        .en_i   (state_q == ST_GAP),
        .tick_o (pace_tick)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    data_d  = cmd_data;
                    len_d   = LEN_W'(clamp_len(32'(cmd_len), WIDTH));
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
                    // sr_q only reflects this final shift after the edge, so form the
                    // post-shift word here to have it ready on the first DONE cycle.
                    rsp_d   = {sr_q[WIDTH-2:0], sr_serial_in};
                    state_d = ST_DONE;
                end else if (PACED) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (pace_tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_TX;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign rsp_valid      = (state_q == ST_DONE);
    assign rsp_data       = rsp_q;
    assign sr_load_en     = (state_q == ST_LOAD);
    assign sr_shift_en    = (state_q == ST_SHIFT);
    assign ser_strobe     = sr_shift_en;
    assign sr_parallel_in = (state_q == ST_LOAD && mode_q == MODE_TX) ? data_q : '0;
    assign sr_serial_in   = (state_q != ST_SHIFT) ? 1'b0 :
                            (mode_q == MODE_RX)   ? ser_in : TX_FILL;
    assign ser_out        = (state_q == ST_SHIFT || state_q == ST_GAP) ? sr_q[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: two sequencers (DIV=1 and DIV=4), each driving a behavioural shift register.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid1, cmd_valid4;
    logic       cmd_mode;
    logic [7:0] cmd_data;
    logic [3:0] cmd_len;
    logic       ser_in;
    logic       rsp_ready;

    logic       cmd_ready1, ser_out1, ser_strobe1, rsp_valid1, busy1, load1, shift1, sin1;
    logic [7:0] rsp_data1, pin1;
    logic [7:0] sr1_q = 8'h00;
    logic       cmd_ready4, ser_out4, ser_strobe4, rsp_valid4, busy4, load4, shift4, sin4;
    logic [7:0] rsp_data4, pin4;
    logic [7:0] sr4_q = 8'h00;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] bits;
    int         nshift;
    int         cyc;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(8), .DIV(1), .TX_FILL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_len(cmd_len), .ser_in(ser_in),
        .ser_out(ser_out1), .ser_strobe(ser_strobe1), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .busy(busy1),
        .sr_load_en(load1), .sr_shift_en(shift1), .sr_parallel_in(pin1),
        .sr_serial_in(sin1), .sr_q(sr1_q)
    );

    shift_sequencer #(.WIDTH(8), .DIV(4), .TX_FILL(1'b0)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_len(cmd_len), .ser_in(ser_in),
        .ser_out(ser_out4), .ser_strobe(ser_strobe4), .rsp_valid(rsp_valid4),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data4), .busy(busy4),
        .sr_load_en(load4), .sr_shift_en(shift4), .sr_parallel_in(pin4),
        .sr_serial_in(sin4), .sr_q(sr4_q)
    );

    // Behavioural shift registers: load has priority, shift moves left inserting serial_in.
    always @(posedge clk) begin
        if (load1) sr1_q <= pin1;
        else if (shift1) sr1_q <= {sr1_q[6:0], sin1};
        if (load4) sr4_q <= pin4;
        else if (shift4) sr4_q <= {sr4_q[6:0], sin4};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake on dut1 (cycle c0), then step into LOAD (c1) and check it.
    task automatic issue1(input logic mode, input logic [7:0] data, input logic [3:0] len);
        cmd_mode   = mode;
        cmd_data   = data;
        cmd_len    = len;
        cmd_valid1 = 1'b1;
        chk("c0_ready", 32'(cmd_ready1), 1);
        tick();
        cmd_valid1 = 1'b0;
        chk("c1_load_en", 32'(load1), 1);
        chk("c1_busy", 32'(busy1), 1);
        chk("c1_ready", 32'(cmd_ready1), 0);
        chk("c1_parallel_in", 32'(pin1), mode ? 32'h0 : 32'(data));
    endtask

    // From c1, collect ser_out on every strobe until rsp_valid; cyc_o is the DONE cycle index.
    task automatic run1(output logic [7:0] bits_o, output int n_o, output int cyc_o);
        bits_o = 8'h00;
        n_o    = 0;
        cyc_o  = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid1) begin
                cyc_o = i + 2;
                break;
            end
            if (ser_strobe1) begin
                bits_o = {bits_o[6:0], ser_out1};
                n_o++;
            end
        end
        chk("rsp_valid_reached", 32'(rsp_valid1), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready1), 1);
        chk({tag, "_busy"}, 32'(busy1), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid1), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data1), 0);
        chk({tag, "_load_en"}, 32'(load1), 0);
        chk({tag, "_shift_en"}, 32'(shift1), 0);
        chk({tag, "_parallel_in"}, 32'(pin1), 0);
        chk({tag, "_serial_in"}, 32'(sin1), 0);
        chk({tag, "_ser_out"}, 32'(ser_out1), 0);
        chk({tag, "_ser_strobe"}, 32'(ser_strobe1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cmd_valid1 = 1'b0;
        cmd_valid4 = 1'b0;
        cmd_mode   = 1'b0;
        cmd_data   = 8'h00;
        cmd_len    = 4'd0;
        ser_in     = 1'b0;
        rsp_ready  = 1'b1;
        #2 rst = 1'b0;
        #2;
        chk_reset_outputs("por");
        chk("por4_ready", 32'(cmd_ready4), 1);
        chk("por4_busy", 32'(busy4), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // TX 0xA5, len 8, DIV=1
        issue1(1'b0, 8'hA5, 4'd8);
        run1(bits, nshift, cyc);
        chk("txa5_bits", 32'(bits), 32'hA5);
        chk("txa5_nshift", 32'(nshift), 8);
        chk("txa5_done_cycle", 32'(cyc), 10);
        chk("txa5_rsp_data", 32'(rsp_data1), 0);
        chk("txa5_done_ser_out", 32'(ser_out1), 0);
        tick();
        chk("txa5_idle_ready", 32'(cmd_ready1), 1);
        chk("txa5_idle_rsp_valid", 32'(rsp_valid1), 0);

        // RX len 3, ser_in held high; cmd_data must be ignored
        ser_in = 1'b1;
        issue1(1'b1, 8'hFF, 4'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rx3_strobe", 32'(ser_strobe1), 1);
            chk("rx3_serial_in", 32'(sin1), 1);
        end
        tick();
        chk("rx3_rsp_valid_c5", 32'(rsp_valid1), 1);
        chk("rx3_rsp_data", 32'(rsp_data1), 32'h07);
        chk("rx3_no_strobe_done", 32'(ser_strobe1), 0);
        tick();
        ser_in = 1'b0;

        // TX 0xFF, len 8 on the DIV=4 instance
        cmd_mode   = 1'b0;
        cmd_data   = 8'hFF;
        cmd_len    = 4'd8;
        cmd_valid4 = 1'b1;
        chk("div4_c0_ready", 32'(cmd_ready4), 1);
        tick();
        cmd_valid4 = 1'b0;
        chk("div4_c1_busy", 32'(busy4), 1);
        chk("div4_c1_load_en", 32'(load4), 1);
        for (int c = 2; c <= 31; c++) begin
            logic exp_s;
            tick();
            exp_s = (c <= 30) && ((c - 2) % 4 == 0);
            chk("div4_strobe", 32'(ser_strobe4), 32'(exp_s));
            chk("div4_busy", 32'(busy4), 1);
            chk("div4_rsp_valid", 32'(rsp_valid4), 32'(c == 31));
            if (exp_s) chk("div4_ser_out", 32'(ser_out4), 1);
        end
        chk("div4_rsp_data", 32'(rsp_data4), 0);
        tick();
        chk("div4_idle_busy", 32'(busy4), 0);

        // Backpressure: TX 0x5A len 4, rsp_ready low for 5 DONE cycles, second command waiting
        rsp_ready = 1'b0;
        issue1(1'b0, 8'h5A, 4'd4);
        run1(bits, nshift, cyc);
        chk("bp_bits", 32'(bits), 32'h05);
        chk("bp_nshift", 32'(nshift), 4);
        chk("bp_done_cycle", 32'(cyc), 6);
        cmd_mode   = 1'b0;
        cmd_data   = 8'h81;
        cmd_len    = 4'd0;
        cmd_valid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_rsp_valid", 32'(rsp_valid1), 1);
            chk("bp_hold_rsp_data", 32'(rsp_data1), 32'hA0);
            chk("bp_hold_cmd_ready", 32'(cmd_ready1), 0);
            tick();
        end
        rsp_ready = 1'b1;
        chk("bp_hs_rsp_valid", 32'(rsp_valid1), 1);
        chk("bp_hs_cmd_ready", 32'(cmd_ready1), 0);
        tick();
        chk("bp_accept_ready", 32'(cmd_ready1), 1);
        chk("bp_accept_busy", 32'(busy1), 0);
        tick();
        cmd_valid1 = 1'b0;
        chk("len0_load_en", 32'(load1), 1);
        chk("len0_parallel_in", 32'(pin1), 32'h81);
        run1(bits, nshift, cyc);
        chk("len0_bits", 32'(bits), 32'h81);
        chk("len0_nshift", 32'(nshift), 8);
        chk("len0_done_cycle", 32'(cyc), 10);
        tick();

        // Length 9 clamps to 8
        issue1(1'b0, 8'h96, 4'd9);
        run1(bits, nshift, cyc);
        chk("len9_bits", 32'(bits), 32'h96);
        chk("len9_nshift", 32'(nshift), 8);
        chk("len9_done_cycle", 32'(cyc), 10);
        tick();

        // RX len 4 of ones leaves a nonzero rsp_data for the reset test
        ser_in = 1'b1;
        issue1(1'b1, 8'h00, 4'd4);
        run1(bits, nshift, cyc);
        chk("rx4_nshift", 32'(nshift), 4);
        chk("rx4_rsp_data", 32'(rsp_data1), 32'h0F);
        tick();
        ser_in = 1'b0;

        // Reset during the 4th shift of a TX
        issue1(1'b0, 8'hA5, 4'd8);
        repeat (4) tick();
        chk("mid_4th_strobe", 32'(ser_strobe1), 1);
        chk("mid_rsp_data_held", 32'(rsp_data1), 32'h0F);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(cmd_ready1), 1);
        chk("post_rst_busy", 32'(busy1), 0);

        issue1(1'b0, 8'h3C, 4'd8);
        run1(bits, nshift, cyc);
        chk("tx3c_bits", 32'(bits), 32'h3C);
        chk("tx3c_nshift", 32'(nshift), 8);
        chk("tx3c_done_cycle", 32'(cyc), 10);
        tick();
        chk("tx3c_idle_ready", 32'(cmd_ready1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
